y86_alu_pipe: RTL and testbench
===============================

# y86_alu_pipe

Parametrised, two-stage pipelined Y86 execute-stage ALU with a valid/ready handshake on both sides and a registered condition-code (CC) unit. It generalises the fixed 64-bit single-function logic units (and64bit and siblings) to any WIDTH. It performs all four Y86 OPq functions (add, sub, and, xor) and updates ZF/SF/OF only when requested. It sits between decode/operand fetch and memory/write-back in the pipelined Y86 core.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits (≥ 2)
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline kill (e.g. mispredict)
- in_valid  input  1  operation presented
- in_ready  output  1  operation accepted this cycle when in_valid && in_ready
- alu_fun  input  2  0=ADD, 1=SUB, 2=AND, 3=XOR (Y86 ifun encoding)
- a  input  WIDTH  valA (rA operand)
- b  input  WIDTH  valB (rB operand)
- set_cc  input  1  this op updates CC when it retires
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  valE
- cc_zf, cc_sf, cc_of  output  1 each  registered condition codes

## Operation
- Functions: ADD → b + a; SUB → b − a (Y86 subq: rB − rA); AND → b & a; XOR → b ^ a. All mod 2^WIDTH, two's complement.
- Flags of an op, computed on its WIDTH-bit result r:
  - ZF = (r == 0)
  - SF = r[WIDTH-1]
  - OF (ADD) = (a and b same sign) && (r sign ≠ a sign)
  - OF (SUB) = (a and b differ in sign) && (r sign ≠ b sign)
  - OF (AND, XOR) = 0
- Stage 1 (S1) registers {alu_fun, a, b, set_cc} on accept.
- Stage 2 (S2) registers the result, the flags and set_cc from S1.
- CC registers load the S2 flags only on output transfer (out_valid && out_ready) with S2.set_cc = 1. Otherwise they hold.
- rst:
  - S1 and S2 valid bits clear, so out_valid = 0 and in_ready = 1 the next cycle.
  - {cc_zf, cc_sf, cc_of} = CC_RESET.
  - result = 0.
  - Any in-flight ops are discarded.
- flush: clears S1/S2 valid bits; CC is unchanged; an input offered in the same cycle is not accepted. rst has priority over flush.

## Timing
- Latency: an op accepted at edge N appears with out_valid = 1 after edge N+1. If unstalled, it transfers at edge N+2.
- Throughput: 1 op/cycle when out_ready stays high.
- Stage advance rules:
  - S2 loads when !S2.valid || out_ready.
  - S1 advances when S2 loads.
  - in_ready = !flush && (!S1.valid || S2 loads). This is combinational from out_ready; there is no skid buffer.
- Backpressure: with out_ready held low, at most 2 ops are buffered. in_ready falls once both stages are full.
- Payload stability: result, out_valid and payload hold stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order.
- Same-edge CC and input: when a CC update and a new input occur on the same edge, CC reflects the retiring op. CC is never forwarded to in-flight ops.
- Reset mid-stall: no transfer occurs on the reset edge, and CC is not updated by the op that was stalled in S2.

## Structure
- Package y86_alu_pkg holds:
  - the alu_fun constants ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR
  - the CC bit positions and the default CC_RESET
- Sub-module y86_alu_core: purely combinational, parametrised by WIDTH. It maps (alu_fun, a, b) to (r, zf, sf, of) and is instantiated between S1 and S2.
- The top level holds the pipeline registers, the handshake and the CC registers only.

## Test plan
- WIDTH=64, out_ready=1: ADD a=1, b=5, set_cc=1 → result=6 two cycles after accept; ZF/SF/OF = 0/0/0.
- AND a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFB → 0x8000_0000_0000_0000, SF=1, OF=0. Then XOR a=b=0x7FFF_FFFF_FFFF_FFFF with set_cc=0 → result 0, CC unchanged.
- Overflow cases:
  - ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → 0x8000_0000_0000_0000, SF=1, OF=1.
  - SUB a=1, b=0x8000_0000_0000_0000 → 0x7FFF_FFFF_FFFF_FFFF, OF=1.
  - SUB a=5, b=5 → 0, ZF=1.
- Backpressure: issue 3 ADDs back-to-back with out_ready=0 → in_ready drops after 2 accepts. Hold for 4 cycles, then release → results emerge in order, unchanged while stalled, and the third op is accepted on release.
- Reset/flush:
  - Assert rst with 2 ops buffered → next cycle out_valid=0, in_ready=1, CC=ZF1/SF0/OF0.
  - Assert flush alone → buffer empties and CC is unchanged.
- WIDTH=8 instance: ADD 0x7F+0x01 → 0x80, OF=1, SF=1. SUB a=0x01, b=0x00 → 0xFF, SF=1, OF=0.

Source files
------------

// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: shared ALU function codes and condition-code layout for the Y86 execute pipe
package y86_alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET_DEF = 3'b100;
endpackage

// File: rtl/y86_alu_core.sv
// y86_alu_core: combinational Y86 OPq function unit producing valE and its ZF/SF/OF
module y86_alu_core import y86_alu_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  logic sa, sb, sr;
  always_comb begin
    r = alu_fun == ALU_ADD ? b + a :
        alu_fun == ALU_SUB ? b - a :
        alu_fun == ALU_AND ? b & a : b ^ a;
    sa = a[WIDTH-1];
    sb = b[WIDTH-1];
    sr = r[WIDTH-1];
    zf = r == '0;
    sf = sr;
    // subq computes rB - rA, so overflow is judged against the sign of b
    of = alu_fun == ALU_ADD ? (sa == sb) && (sr != sa) :
         alu_fun == ALU_SUB ? (sa != sb) && (sr != sb) : 1'b0;
  end
endmodule

// File: rtl/y86_alu_pipe.sv
// y86_alu_pipe: two-stage valid/ready Y86 execute ALU with condition codes loaded on retirement
module y86_alu_pipe import y86_alu_pkg::*; #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = CC_RESET_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);
  logic             s1_valid, s1_set_cc, s2_valid, s2_set_cc;
  logic [1:0]       s1_fun;
  logic [WIDTH-1:0] s1_a, s1_b, s2_r, r;
  logic [2:0]       s2_flags, cc;
  logic             zf, sf, of, s2_load, accept, retire;
  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !flush && (!s1_valid || s2_load);
  assign accept    = in_valid && in_ready;
  // a killed pipe leaves CC untouched even if the head op would have transferred
  assign retire    = s2_valid && out_ready && s2_set_cc && !flush;
  assign out_valid = s2_valid;
  assign result    = s2_r;
  assign cc_zf     = cc[CC_ZF];
  assign cc_sf     = cc[CC_SF];
  assign cc_of     = cc[CC_OF];
  y86_alu_core #(.WIDTH(WIDTH)) core (
    .alu_fun(s1_fun),
    .a(s1_a),
    .b(s1_b),
    .r(r),
    .zf(zf),
    .sf(sf),
    .of(of)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept ? 1'b1 : s2_load ? 1'b0 : s1_valid;
      if (s2_load) s2_valid <= s1_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_fun    <= alu_fun;
      s1_a      <= a;
      s1_b      <= b;
      s1_set_cc <= set_cc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_r      <= '0;
      s2_flags  <= '0;
      s2_set_cc <= 1'b0;
      cc        <= CC_RESET;
    end else begin
      if (s2_load && s1_valid) begin
        s2_r            <= r;
        s2_flags[CC_ZF] <= zf;
        s2_flags[CC_SF] <= sf;
        s2_flags[CC_OF] <= of;
        s2_set_cc       <= s1_set_cc;
      end
      if (retire) cc <= s2_flags;
    end
  end
endmodule

// File: tb/tb_y86_alu_pipe.sv
// tb_y86_alu_pipe: directed checks of the 64-bit and 8-bit Y86 ALU pipes
module tb_y86_alu_pipe;
  import y86_alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, set_cc = 1'b0, out_ready = 1'b1;
  logic [1:0]  alu_fun = 2'd0;
  logic [63:0] a = '0, b = '0;
  logic        in_ready, out_valid, cc_zf, cc_sf, cc_of;
  logic [63:0] result;
  logic        in_valid8 = 1'b0, set_cc8 = 1'b0, out_ready8 = 1'b1;
  logic [1:0]  alu_fun8 = 2'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, zf8, sf8, of8;
  logic [7:0]  result8;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  y86_alu_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_fun(alu_fun), .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  y86_alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_fun(alu_fun8), .a(a8), .b(b8), .set_cc(set_cc8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .cc_zf(zf8), .cc_sf(sf8), .cc_of(of8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [63:0] x, input logic [63:0] y, input logic s);
    in_valid = 1'b1;
    alu_fun  = f;
    a        = x;
    b        = y;
    set_cc   = s;
  endtask

  task automatic run_op(input string tag, input logic [1:0] f, input logic [63:0] x, input logic [63:0] y,
                        input logic s, input logic [63:0] er, input logic [2:0] ecc);
    drive(f, x, y, s);
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, result, er);
    tick();
    chk({tag, "_cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, ecc});
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    chk("reset_result", result, 64'd0);

    run_op("add_1_5", ALU_ADD, 64'd1, 64'd5, 1'b1, 64'd6, 3'b000);
    run_op("and_sign", ALU_AND, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1,
           64'h8000_0000_0000_0000, 3'b010);
    run_op("xor_nocc", ALU_XOR, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 3'b010);
    run_op("add_ovf", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 3'b011);
    run_op("sub_ovf", ALU_SUB, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
    run_op("sub_zero", ALU_SUB, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100);

    out_ready = 1'b0;
    drive(ALU_ADD, 64'd1, 64'd10, 1'b0);
    #1;
    chk("bp_ready_0", {63'd0, in_ready}, 64'd1);
    tick();
    drive(ALU_ADD, 64'd2, 64'd10, 1'b0);
    #1;
    chk("bp_ready_1", {63'd0, in_ready}, 64'd1);
    tick();
    drive(ALU_ADD, 64'd3, 64'd10, 1'b0);
    #1;
    chk("bp_ready_full", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_result", result, 64'd11);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second", result, 64'd12);
    tick();
    chk("bp_third", result, 64'd13);
    chk("bp_third_valid", {63'd0, out_valid}, 64'd1);
    tick();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);
    chk("bp_cc_kept", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);

    run_op("pre_rst", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 3'b011);
    out_ready = 1'b0;
    drive(ALU_ADD, 64'd1, 64'd1, 1'b1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("rst_buffered", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    chk("rst_result", result, 64'd0);

    out_ready = 1'b0;
    drive(ALU_ADD, 64'd1, 64'd1, 1'b1);
    tick();
    tick();
    chk("fl_buffered", {63'd0, out_valid}, 64'd1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    tick();
    chk("fl_no_accept", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;

    in_valid8 = 1'b1; alu_fun8 = ALU_ADD; a8 = 8'h01; b8 = 8'h7F; set_cc8 = 1'b1;
    tick();
    alu_fun8 = ALU_SUB; a8 = 8'h01; b8 = 8'h00;
    tick();
    in_valid8 = 1'b0;
    chk("w8_add_result", {56'd0, result8}, 64'h80);
    tick();
    chk("w8_add_cc", {61'd0, zf8, sf8, of8}, 64'd3);
    chk("w8_sub_result", {56'd0, result8}, 64'hFF);
    tick();
    chk("w8_sub_cc", {61'd0, zf8, sf8, of8}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
